// File: rtl/bram_frame_reader_if.sv
// BRAM read port and FIFO write port of the frame reader, bundled as one bus.
// master = the reader engine, slave = the BRAM/FIFO side.
interface bram_frame_reader_if #(
   parameter int AW     = 14,
   parameter int DATA_W = 12
);
   logic              ren;
   logic [AW-1:0]     raddr;
   logic [DATA_W-1:0] rdata;
   logic              wr;
   logic [DATA_W-1:0] wdata;
   logic              almostfull;

   modport master (output ren, raddr, wr, wdata, input rdata, almostfull);
   modport slave  (input ren, raddr, wr, wdata, output rdata, almostfull);
endinterface

// File: rtl/bram_frame_reader.sv
// Frame-buffer read engine: streams a base/length window of a BRAM frame
// store (with address wrap) into a FIFO, single-shot or continuous, with
// almost-full back-pressure and a per-frame done pulse.
module bram_frame_reader #(
   parameter  int BRAM_DEPTH  = 16384,
   parameter  int DATA_W      = 12,
   parameter  int RD_LAT      = 1,
   parameter  int SYNC_STAGES = 2,
   localparam int AW          = $clog2(BRAM_DEPTH)
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_req,
   input  logic                i_cont,
   input  logic [AW-1:0]       i_base,
   input  logic [AW:0]         i_len,
   bram_frame_reader_if.master bus,
   output logic                o_busy,
   output logic                o_done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] req_sync;
   logic                   req_s, req_d, req_rise;
   logic [AW-1:0]          addr, next_addr;
   logic [AW:0]            remaining, len_eff;
   logic                   cont;
   logic                   issue, last_issue;
   // bit 0 mirrors o_ren; bit RD_LAT lines up with valid i_rdata
   logic [RD_LAT:0]        vld_pipe, lst_pipe;

   assign req_s      = req_sync[SYNC_STAGES-1];
   assign issue      = (state == RUN) && !bus.almostfull;
   assign last_issue = issue && (remaining == (AW+1)'(1));
   assign next_addr  = (addr == AW'(BRAM_DEPTH-1)) ? '0 : addr + AW'(1);
   assign o_busy     = (state != IDLE);

   // Zero or oversize length selects the whole frame store
   always_comb begin
      len_eff = i_len;
      if (i_len == '0 || i_len > (AW+1)'(BRAM_DEPTH))
         len_eff = (AW+1)'(BRAM_DEPTH);
   end

   // Request synchroniser plus registered rising-edge detect
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         req_sync <= '0;
         req_d    <= 1'b0;
         req_rise <= 1'b0;
      end else begin
         req_sync <= {req_sync[SYNC_STAGES-2:0], i_req};
         req_d    <= req_s;
         req_rise <= req_s & ~req_d;
      end
   end

   // Frame FSM and read issue; a continuous frame reloads on its last issue
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         cont      <= 1'b0;
         bus.ren   <= 1'b0;
         bus.raddr <= '0;
      end else begin
         bus.ren <= issue;
         if (issue)
            bus.raddr <= addr;
         case (state)
            IDLE: begin
               if (req_rise) begin
                  addr      <= i_base;
                  remaining <= len_eff;
                  cont      <= i_cont;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (issue) begin
                  if (last_issue) begin
                     if (cont && req_s) begin
                        addr      <= i_base;
                        remaining <= len_eff;
                        cont      <= i_cont;
                     end else begin
                        state <= DRAIN;
                     end
                  end else begin
                     addr      <= next_addr;
                     remaining <= remaining - (AW+1)'(1);
                  end
               end
            end
            DRAIN: begin
               if (vld_pipe == '0)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read-valid/last-word pipe and FIFO write stage; reads in flight always land
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         vld_pipe  <= '0;
         lst_pipe  <= '0;
         bus.wr    <= 1'b0;
         bus.wdata <= '0;
         o_done    <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[RD_LAT-1:0], issue};
         lst_pipe <= {lst_pipe[RD_LAT-1:0], last_issue};
         bus.wr   <= vld_pipe[RD_LAT];
         o_done   <= vld_pipe[RD_LAT] & lst_pipe[RD_LAT];
         if (vld_pipe[RD_LAT])
            bus.wdata <= bus.rdata;
      end
   end

endmodule

// File: tb/tb_bram_frame_reader.sv
// Bench for bram_frame_reader: two instances (RD_LAT=1 and RD_LAT=2,
// BRAM_DEPTH=16) share stimulus; a BRAM model returns addr+0x100 and
// address/data scoreboards are filled when a frame is requested.
module tb_bram_frame_reader;
   localparam int AW = 4;
   localparam int DW = 12;

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic          req  = 1'b0;
   logic          cont = 1'b0;
   logic          af   = 1'b0;
   logic          af_q = 1'b0;
   logic [AW-1:0] base = '0;
   logic [AW:0]   len  = '0;

   always #5 clk = ~clk;

   bram_frame_reader_if #(.AW(AW), .DATA_W(DW)) bus0 ();
   bram_frame_reader_if #(.AW(AW), .DATA_W(DW)) bus1 ();

   wire  [1:0]    busy_v, done_v, ren_v, wr_v;
   wire  [AW-1:0] raddr_a [2];
   wire  [DW-1:0] wdata_a [2];
   logic [DW-1:0] p1;

   assign ren_v      = {bus1.ren, bus0.ren};
   assign wr_v       = {bus1.wr, bus0.wr};
   assign raddr_a[0] = bus0.raddr;
   assign raddr_a[1] = bus1.raddr;
   assign wdata_a[0] = bus0.wdata;
   assign wdata_a[1] = bus1.wdata;
   assign bus0.almostfull = af;
   assign bus1.almostfull = af;

   bram_frame_reader #(.BRAM_DEPTH(16), .DATA_W(DW), .RD_LAT(1), .SYNC_STAGES(2)) u_dut0 (
      .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_cont(cont), .i_base(base), .i_len(len),
      .bus(bus0.master), .o_busy(busy_v[0]), .o_done(done_v[0]));

   bram_frame_reader #(.BRAM_DEPTH(16), .DATA_W(DW), .RD_LAT(2), .SYNC_STAGES(2)) u_dut1 (
      .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_cont(cont), .i_base(base), .i_len(len),
      .bus(bus1.master), .o_busy(busy_v[1]), .o_done(done_v[1]));

   function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
      return DW'(12'h100) + DW'(a);
   endfunction

   // BRAM models: one-cycle and two-cycle read latency
   always @(posedge clk) begin
      if (bus0.ren) bus0.rdata <= mem(bus0.raddr);
      if (bus1.ren) p1 <= mem(bus1.raddr);
      bus1.rdata <= p1;
      af_q <= af;
   end

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic          fin;
   } exp_t;

   exp_t          exp_q  [2][$];
   logic [AW-1:0] addr_q [2][$];
   int            ren_cnt [2];
   int            busy_chk [2];
   int            n_tests = 0;
   int            n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_frame(input int b, input int l, input bit fin);
      exp_t e;
      for (int i = 0; i < l; i++) begin
         int a;
         a = (b + i) % 16;
         e.data = mem(AW'(a));
         e.last = (i == l - 1);
         e.fin  = fin && (i == l - 1);
         for (int d = 0; d < 2; d++) begin
            addr_q[d].push_back(AW'(a));
            exp_q[d].push_back(e);
         end
      end
   endtask

   task automatic wait_ren(input int n);
      int start;
      bit ok;
      start = ren_cnt[0];
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (ren_cnt[0] - start >= n) begin ok = 1; break; end
      end
      chk("ren_wait", 32'(ok), 1);
   endtask

   task automatic wait_done(input int budget, input bit toggle_af);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (toggle_af && (i % 3 == 2)) af = ~af;
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && addr_q[0].size() == 0 &&
             addr_q[1].size() == 0 && busy_v == 2'b00) begin
            ok = 1;
            break;
         end
      end
      af = 1'b0;
      chk("idle_reached", 32'(ok), 1);
   endtask

   task automatic check_rst(input string tag);
      chk({tag, "_ren"}, 32'(ren_v), 0);
      chk({tag, "_raddr"}, 32'({raddr_a[1], raddr_a[0]}), 0);
      chk({tag, "_wr"}, 32'(wr_v), 0);
      chk({tag, "_wdata"}, 32'({wdata_a[1], wdata_a[0]}), 0);
      chk({tag, "_busy"}, 32'(busy_v), 0);
      chk({tag, "_done"}, 32'(done_v), 0);
   endtask

   // Scoreboard monitor: reads against the address queue, writes against the data queue
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (busy_chk[d] > 0) begin
            chk($sformatf("busy_after_last%0d", d), 32'(busy_v[d]), 0);
            busy_chk[d]--;
         end
         if (ren_v[d] === 1'b1) begin
            ren_cnt[d]++;
            chk($sformatf("ren_while_af%0d", d), 32'(af_q), 0);
            chk($sformatf("raddr_avail%0d", d), 32'(addr_q[d].size() != 0), 1);
            if (addr_q[d].size() != 0)
               chk($sformatf("raddr%0d", d), 32'(raddr_a[d]), 32'(addr_q[d].pop_front()));
         end
         if (done_v[d] === 1'b1)
            chk($sformatf("done_with_wr%0d", d), 32'(wr_v[d]), 1);
         if (wr_v[d] === 1'b1) begin
            chk($sformatf("wr_avail%0d", d), 32'(exp_q[d].size() != 0), 1);
            if (exp_q[d].size() != 0) begin
               exp_t e;
               e = exp_q[d].pop_front();
               chk($sformatf("wdata%0d", d), 32'(wdata_a[d]), 32'(e.data));
               chk($sformatf("done%0d", d), 32'(done_v[d]), 32'(e.last));
               if (e.fin) begin
                  chk($sformatf("busy_at_last%0d", d), 32'(busy_v[d]), 1);
                  busy_chk[d] = 2;
               end
            end
         end
      end
   end

   logic [7:0] bsy, rn, w0, w1;

   initial begin
      // reset state
      repeat (3) tick();
      check_rst("init");
      rstn = 1'b1;
      repeat (2) tick();

      // single-shot, len=0 -> whole store, with start-up latency checks
      base = 4'd0; len = '0; cont = 1'b0;
      push_frame(0, 16, 1);
      req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         bsy[k] = busy_v[0]; rn[k] = ren_v[0]; w0[k] = wr_v[0]; w1[k] = wr_v[1];
      end
      chk("busy_k2", 32'(bsy[2]), 0);
      chk("busy_k3", 32'(bsy[3]), 1);
      chk("ren_k3", 32'(rn[3]), 0);
      chk("ren_k4", 32'(rn[4]), 1);
      chk("wr0_k5", 32'(w0[5]), 0);
      chk("wr0_k6", 32'(w0[6]), 1);
      chk("wr1_k6", 32'(w1[6]), 0);
      chk("wr1_k7", 32'(w1[7]), 1);
      wait_done(200, 0);
      req = 1'b0;
      repeat (4) tick();

      // wrap: base 14, len 5 -> 14,15,0,1,2
      base = 4'd14; len = 5'd5;
      push_frame(14, 5, 1);
      req = 1'b1;
      wait_done(200, 0);
      req = 1'b0;
      repeat (4) tick();

      // back-pressure: almost-full toggles every 3 cycles
      base = 4'd0; len = 5'd16;
      push_frame(0, 16, 1);
      req = 1'b1;
      wait_done(400, 1);
      req = 1'b0;
      repeat (4) tick();

      // continuous, len 4; request dropped during frame 4
      base = 4'd0; len = 5'd4; cont = 1'b1;
      for (int f = 0; f < 4; f++) push_frame(0, 4, f == 3);
      req = 1'b1;
      wait_ren(1);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("cont_ren", 32'(ren_v[0]), 1);
         if (i == 12) req = 1'b0;
      end
      tick();
      chk("cont_stop", 32'(ren_v[0]), 0);
      wait_done(200, 0);
      cont = 1'b0;
      repeat (4) tick();

      // reset after 7 of 16 reads
      base = 4'd0; len = 5'd16;
      push_frame(0, 16, 1);
      req = 1'b1;
      wait_ren(7);
      rstn = 1'b0;
      req  = 1'b0;
      for (int d = 0; d < 2; d++) begin
         exp_q[d].delete();
         addr_q[d].delete();
      end
      tick();
      check_rst("midrst");
      rstn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("no_wr_after_rst", 32'(wr_v), 0);
      end
      push_frame(0, 4, 1);
      base = 4'd0; len = 5'd4;
      req = 1'b1;
      wait_done(200, 0);
      req = 1'b0;
      repeat (4) tick();

      // request glitch during RUN is ignored; next edge after IDLE uses base 8
      base = 4'd0; len = 5'd16;
      push_frame(0, 16, 1);
      req = 1'b1;
      wait_ren(2);
      req = 1'b0;
      repeat (2) tick();
      req = 1'b1;
      repeat (3) tick();
      req = 1'b0;
      wait_done(200, 0);
      repeat (3) tick();
      base = 4'd8; len = 5'd4;
      push_frame(8, 4, 1);
      req = 1'b1;
      wait_done(200, 0);
      req = 1'b0;
      repeat (4) tick();
      chk("sb_left", 32'(exp_q[0].size() + exp_q[1].size() + addr_q[0].size() + addr_q[1].size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
